// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and constants for the HUB75 scan engine.
//   scan_state_e        : scan FSM states (shift, latch, display)
//   R_LSB/G_LSB/B_LSB   : channel bit offsets inside a pixel word
//   P_TOP/P_BOT/P_DATA/P_CLK : per-column shift phases
//   gamma8()            : 8-bit square-law gamma map, v' = (v*v) >> 8
package hub75_pkg;

  typedef enum logic [1:0] {
    StShift   = 2'd0,
    StLatch   = 2'd1,
    StDisplay = 2'd2
  } scan_state_e;

  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_LSB = 0;

  typedef logic [1:0] phase_t;

  localparam phase_t P_TOP  = 2'd0;  // present top-row address
  localparam phase_t P_BOT  = 2'd1;  // present bottom-row address, top word arrives
  localparam phase_t P_DATA = 2'd2;  // bottom word arrives, colour bits valid
  localparam phase_t P_CLK  = 2'd3;  // shift clock high

  function automatic logic [7:0] gamma8(input logic [7:0] v);
    logic [15:0] sq;
    sq = v * v;
    return sq[15:8];
  endfunction

endpackage

// File: rtl/hub75_if.sv
// hub75_if: RAM read port plus HUB75 panel pins of the scan engine.
//   raddr/rdata        : pixel RAM read port (1-cycle read latency)
//   hub_r0/g0/b0       : top-half colour bits
//   hub_r1/g1/b1       : bottom-half colour bits
//   hub_clk/lat/oe_n   : panel shift clock, latch strobe, active-low output enable
//   hub_addr           : panel row-pair select
//   frame_start        : one-cycle pulse at the start of each frame
// master: the scan engine. slave: the RAM / panel side.
interface hub75_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned ROW_W  = 5
);
  logic [ADDR_W-1:0] raddr;
  logic [31:0]       rdata;
  logic              hub_r0, hub_g0, hub_b0;
  logic              hub_r1, hub_g1, hub_b1;
  logic              hub_clk;
  logic              hub_lat;
  logic              hub_oe_n;
  logic [ROW_W-1:0]  hub_addr;
  logic              frame_start;

  modport master (
    output raddr,
    input  rdata,
    output hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1,
    output hub_clk, hub_lat, hub_oe_n, hub_addr, frame_start
  );

  modport slave (
    input  raddr,
    output rdata,
    input  hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1,
    input  hub_clk, hub_lat, hub_oe_n, hub_addr, frame_start
  );
endinterface

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: output-enable timer for one BCM plane.
//   sysclk, rst : clock, synchronous active-high reset
//   start       : load BASE_TICKS << plane and open OE from the next cycle
//   plane       : current bit plane
//   done        : high in the last enabled cycle
//   oe_n        : panel output enable, active low, registered
module hub75_bcm_timer #(
  parameter int unsigned BITS       = 8,
  parameter int unsigned BASE_TICKS = 4,
  parameter int unsigned PLANE_W    = 3
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               start,
  input  logic [PLANE_W-1:0] plane,
  output logic               done,
  output logic               oe_n
);

  // Wide enough for BASE_TICKS << (BITS-1) without overflow.
  localparam int unsigned CNT_W = BITS + $clog2(BASE_TICKS);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] load;
  logic             oe_n_q;

  assign load = CNT_W'(BASE_TICKS) << plane;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      cnt_q  <= '0;
      oe_n_q <= 1'b1;
    end else if (start) begin
      cnt_q  <= load - 1'b1;
      oe_n_q <= 1'b0;
    end else if (!oe_n_q) begin
      if (cnt_q == '0) begin
        oe_n_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign done = !oe_n_q && (cnt_q == '0);
  assign oe_n = oe_n_q;

endmodule

// File: rtl/hub75_scan.sv
// hub75_scan: framebuffer-to-HUB75 scan engine with binary-coded modulation.
//   sysclk : clock, all logic on posedge
//   rst    : synchronous active-high reset
//   bus    : hub75_if.master (RAM read port and panel pins)
// Scans row pairs (r, r+HEIGHT/2); per plane: 4 cycles per column of shifting, one latch
// cycle, then BASE_TICKS << plane cycles of output enable.
// Build option: define HUB75_GAMMA_EN to square-law map each colour channel before the
// plane bit-select; timing is identical either way.
module hub75_scan
  import hub75_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned HEIGHT     = 64,
  parameter int unsigned BITS       = 8,
  parameter int unsigned BASE_TICKS = 4,
  parameter int unsigned ADDR_W     = 12
) (
  input logic      sysclk,
  input logic      rst,
  hub75_if.master  bus
);

  localparam int unsigned HALF    = HEIGHT / 2;
  localparam int unsigned COL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ROW_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [COL_W-1:0]   ColLast   = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]   RowLast   = ROW_W'(HALF - 1);
  localparam logic [PLANE_W-1:0] PlaneLast = PLANE_W'(BITS - 1);
  localparam logic [ADDR_W-1:0]  WidthAddr = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0]  HalfAddr  = ADDR_W'(HALF);

  scan_state_e        state_q, state_d;
  phase_t             phase_q, phase_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PLANE_W-1:0] plane_q, plane_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic [23:0]        top_q;
  logic [23:0]        bot_px;
  logic [5:0]         rgb_q, rgb_live;
  logic               hub_clk_q, hub_lat_q;
  logic [ROW_W-1:0]   hub_addr_q;
  logic               origin_q;
  logic               data_phase;
  logic               timer_start, timer_done;
  logic               unused_rdata_hi;

  function automatic logic [23:0] map_pixel(input logic [31:0] w);
`ifdef HUB75_GAMMA_EN
    return {gamma8(w[R_LSB +: 8]), gamma8(w[G_LSB +: 8]), gamma8(w[B_LSB +: 8])};
`else
    return {w[R_LSB +: 8], w[G_LSB +: 8], w[B_LSB +: 8]};
`endif
  endfunction

  function automatic logic [2:0] plane_bits(input logic [23:0] px,
                                            input logic [PLANE_W-1:0] pl);
    logic [7:0] r, g, b;
    r = px[23:16];
    g = px[15:8];
    b = px[7:0];
    return {r[pl], g[pl], b[pl]};
  endfunction

  assign unused_rdata_hi = ^bus.rdata[31:24];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    col_d   = col_q;
    row_d   = row_q;
    plane_d = plane_q;
    unique case (state_q)
      StShift: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == P_CLK) begin
          if (col_q == ColLast) begin
            col_d   = '0;
            state_d = StLatch;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StLatch: state_d = StDisplay;
      StDisplay: begin
        if (timer_done) begin
          state_d = StShift;
          if (plane_q == PlaneLast) begin
            plane_d = '0;
            row_d   = (row_q == RowLast) ? '0 : row_q + 1'b1;
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end
      end
      default: state_d = StShift;
    endcase
  end

  // Address is registered from the next-state values so it is valid during P_TOP/P_BOT.
  always_comb begin
    raddr_d = raddr_q;
    if (state_d == StShift) begin
      if (phase_d == P_TOP) begin
        raddr_d = ADDR_W'(row_d) * WidthAddr + ADDR_W'(col_d);
      end else if (phase_d == P_BOT) begin
        raddr_d = (ADDR_W'(row_d) + HalfAddr) * WidthAddr + ADDR_W'(col_d);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Colour path: bottom word only arrives during P_DATA, so colour is driven straight
  // from the RAM in that cycle and held from a register afterwards. This keeps data
  // stable across the P_CLK rising edge without adding a pipeline stage.
  // ---------------------------------------------------------------------------
  assign bot_px     = map_pixel(bus.rdata);
  assign rgb_live   = {plane_bits(top_q, plane_q), plane_bits(bot_px, plane_q)};
  assign data_phase = (state_q == StShift) && (phase_q == P_DATA);

  assign {bus.hub_r0, bus.hub_g0, bus.hub_b0, bus.hub_r1, bus.hub_g1, bus.hub_b1} =
      data_phase ? rgb_live : rgb_q;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q    <= StShift;
      phase_q    <= P_TOP;
      col_q      <= '0;
      row_q      <= '0;
      plane_q    <= '0;
      raddr_q    <= '0;
      top_q      <= '0;
      rgb_q      <= '0;
      hub_clk_q  <= 1'b0;
      hub_lat_q  <= 1'b0;
      hub_addr_q <= '0;
      origin_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      col_q     <= col_d;
      row_q     <= row_d;
      plane_q   <= plane_d;
      raddr_q   <= raddr_d;
      hub_clk_q <= (state_d == StShift) && (phase_d == P_CLK);
      hub_lat_q <= (state_d == StLatch);
      if ((state_q == StShift) && (phase_q == P_BOT)) begin
        top_q <= map_pixel(bus.rdata);
      end
      if (data_phase) begin
        rgb_q <= rgb_live;
      end
      if (state_d == StLatch) begin
        hub_addr_q <= row_d;
      end
      origin_q <= (state_d == StShift) && (phase_d == P_TOP) && (col_d == '0) &&
                  (row_d == '0) && (plane_d == '0);
    end
  end

  assign timer_start = (state_q == StLatch);

  hub75_bcm_timer #(
    .BITS       (BITS),
    .BASE_TICKS (BASE_TICKS),
    .PLANE_W    (PLANE_W)
  ) u_timer (
    .sysclk (sysclk),
    .rst    (rst),
    .start  (timer_start),
    .plane  (plane_q),
    .done   (timer_done),
    .oe_n   (bus.hub_oe_n)
  );

  assign bus.raddr    = raddr_q;
  assign bus.hub_clk  = hub_clk_q;
  assign bus.hub_lat  = hub_lat_q;
  assign bus.hub_addr = hub_addr_q;
  // Reset leaves the engine sitting at the frame origin; the pulse shows in the first
  // cycle after release and on every later wrap to row 0, plane 0.
  assign bus.frame_start = origin_q & ~rst;

endmodule

// File: tb/tb_hub75_scan.sv
module tb_hub75_scan;

  // Reduced panel height keeps a full frame short; width, planes and tick base are nominal.
  localparam int unsigned WIDTH      = 64;
  localparam int unsigned HEIGHT     = 8;
  localparam int unsigned BITS       = 8;
  localparam int unsigned BASE_TICKS = 4;
  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned HALF       = HEIGHT / 2;
  localparam int unsigned ROW_W      = $clog2(HALF);
  localparam int unsigned SHIFT_CYC  = 4 * WIDTH;
  localparam int unsigned ROW_CYC    = BITS * (SHIFT_CYC + 1) + BASE_TICKS * ((1 << BITS) - 1);
  localparam int unsigned FRAME_CYC  = HALF * ROW_CYC;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  always #5 sysclk = ~sysclk;

  hub75_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) bus ();

  hub75_scan #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .BITS       (BITS),
    .BASE_TICKS (BASE_TICKS),
    .ADDR_W     (ADDR_W)
  ) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus)
  );

  logic [31:0] mem [0:4095];
  always @(posedge sysclk) bus.rdata <= mem[bus.raddr];

  int checks = 0;
  int errors = 0;
  int tm     = 0;
  int cyc    = 0;
  bit model_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", name, tm, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input logic [31:0] w);
    int r, g, b;
    r = int'(w[23:16]);
    g = int'(w[15:8]);
    b = int'(w[7:0]);
`ifdef HUB75_GAMMA_EN
    r = (r * r) / 256;
    g = (g * g) / 256;
    b = (b * b) / 256;
`endif
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  // Expected outputs from the frame timeline: decompose cycle t into row, plane, offset.
  task automatic compare_cycle(input int t);
    int tf, tr, row, plane, len, off, col, ph, exp_addr;
    bit found;
    logic [23:0] top, bot;
    tf = t % FRAME_CYC;
    row = tf / ROW_CYC;
    tr = tf % ROW_CYC;
    plane = 0;
    found = 1'b0;
    for (int b = 0; b < BITS; b++) begin
      len = SHIFT_CYC + 1 + (BASE_TICKS << b);
      if (!found) begin
        if (tr < len) begin
          plane = b;
          found = 1'b1;
        end else begin
          tr -= len;
        end
      end
    end
    off = tr;
    check("frame_start", int'(bus.frame_start), (tf == 0) ? 1 : 0);
    if (off < SHIFT_CYC) begin
      col = off / 4;
      ph  = off % 4;
      if (plane > 0) exp_addr = row;
      else if (row > 0) exp_addr = row - 1;
      else exp_addr = (t < FRAME_CYC) ? 0 : HALF - 1;
      check("shift_clk", int'(bus.hub_clk), (ph == 3) ? 1 : 0);
      check("shift_lat", int'(bus.hub_lat), 0);
      check("shift_oe_n", int'(bus.hub_oe_n), 1);
      check("shift_addr", int'(bus.hub_addr), exp_addr);
      if (ph == 0) check("raddr_top", int'(bus.raddr), row * WIDTH + col);
      if (ph == 1) check("raddr_bot", int'(bus.raddr), (row + HALF) * WIDTH + col);
      if (ph >= 2) begin
        top = pix(mem[row * WIDTH + col]);
        bot = pix(mem[(row + HALF) * WIDTH + col]);
        check("hub_r0", int'(bus.hub_r0), int'(top[16 + plane]));
        check("hub_g0", int'(bus.hub_g0), int'(top[8 + plane]));
        check("hub_b0", int'(bus.hub_b0), int'(top[plane]));
        check("hub_r1", int'(bus.hub_r1), int'(bot[16 + plane]));
        check("hub_g1", int'(bus.hub_g1), int'(bot[8 + plane]));
        check("hub_b1", int'(bus.hub_b1), int'(bot[plane]));
      end
    end else begin
      check("ld_clk", int'(bus.hub_clk), 0);
      check("ld_lat", int'(bus.hub_lat), (off == SHIFT_CYC) ? 1 : 0);
      check("ld_oe_n", int'(bus.hub_oe_n), (off == SHIFT_CYC) ? 1 : 0);
      check("ld_addr", int'(bus.hub_addr), row);
    end
  endtask

  always @(negedge sysclk) begin
    #1;
    if (model_on) begin
      compare_cycle(tm);
      tm++;
    end
  end

  task automatic step();
    @(negedge sysclk);
    #1;
    cyc++;
  endtask

  task automatic release_reset();
    @(negedge sysclk);
    rst = 1'b0;
    tm = 0;
    model_on = 1'b1;
    #1;
    cyc = 0;
  endtask

  int disp_lit [BITS] = '{4, 8, 16, 32, 64, 128, 256, 512};
  logic [BITS-1:0] r0_seen, b0_seen, b1_seen;
  int n_shift, n_disp, rises, guard;
  logic prev_clk;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[0]                    = 32'h0080_0000;
    mem[HALF * WIDTH]         = 32'h0000_00FF;
    mem[1 * WIDTH + 5]        = 32'h00A5_5A3C;
    mem[(1 + HALF) * WIDTH + 5] = 32'h003C_C3A5;
    mem[2 * WIDTH + 10]       = 32'h0001_0204;
    mem[3 * WIDTH + 63]       = 32'hFF12_3456;
    mem[(3 + HALF) * WIDTH]   = 32'h00FF_FFFF;

    rst = 1'b1;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    #1;
    check("rst_oe_n", int'(bus.hub_oe_n), 1);
    check("rst_lat", int'(bus.hub_lat), 0);
    check("rst_clk", int'(bus.hub_clk), 0);
    check("rst_addr", int'(bus.hub_addr), 0);
    check("rst_raddr", int'(bus.raddr), 0);
    check("rst_frame_start", int'(bus.frame_start), 0);

    release_reset();
    check("first_frame_start", int'(bus.frame_start), 1);

    // Row 0: measure every plane against hand-computed lengths.
    for (int p = 0; p < BITS; p++) begin
      n_shift = 0;
      rises = 0;
      prev_clk = 1'b0;
      while (!bus.hub_lat && n_shift < 2000) begin
        if (n_shift == 3) begin
          r0_seen[p] = bus.hub_r0;
          b0_seen[p] = bus.hub_b0;
          b1_seen[p] = bus.hub_b1;
        end
        if (bus.hub_clk && !prev_clk) rises++;
        prev_clk = bus.hub_clk;
        n_shift++;
        step();
      end
      check("shift_cycles", n_shift, 256);
      check("clk_rises", rises, 64);
      step();
      n_disp = 0;
      while (!bus.hub_oe_n && n_disp < 2000) begin
        n_disp++;
        step();
      end
      check("oe_cycles", n_disp, disp_lit[p]);
    end
    check("row_length", cyc, 3076);
`ifdef HUB75_GAMMA_EN
    check("r0_planes", int'(r0_seen), 'h40);
    check("b1_planes", int'(b1_seen), 'hFE);
`else
    check("r0_planes", int'(r0_seen), 'h80);
    check("b1_planes", int'(b1_seen), 'hFF);
`endif
    check("b0_planes", int'(b0_seen), 'h00);

    // Frame wrap.
    guard = 0;
    while (!bus.frame_start && guard < 20000) begin
      guard++;
      step();
    end
    check("wrap_cycle", cyc, 12304);
    check("wrap_raddr_top", int'(bus.raddr), 0);
    step();
    check("wrap_raddr_bot", int'(bus.raddr), 256);

    // Reset in the middle of a display window.
    guard = 0;
    while (bus.hub_oe_n && guard < 2000) begin
      guard++;
      step();
    end
    step();
    step();
    check("pre_rst_oe_n", int'(bus.hub_oe_n), 0);
    @(negedge sysclk);
    rst = 1'b1;
    model_on = 1'b0;
    #1;
    step();
    check("midrst_oe_n", int'(bus.hub_oe_n), 1);
    check("midrst_lat", int'(bus.hub_lat), 0);
    check("midrst_clk", int'(bus.hub_clk), 0);
    check("midrst_addr", int'(bus.hub_addr), 0);
    check("midrst_raddr", int'(bus.raddr), 0);
    repeat (2) step();
    release_reset();
    check("restart_frame_start", int'(bus.frame_start), 1);
    repeat (600) step();
    model_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
